// File: rtl/hx8352_delay_timer_pkg.sv
// Shared state encodings and width helper for the HX8352 delay timer.
package hx8352_delay_timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Prescaler counter width: ceil(log2(v)), never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hx8352_delay_timer_us_prescaler.sv
// Divides clk down to a one-cycle microsecond tick while enabled.
module hx8352_us_prescaler
  import hx8352_delay_timer_pkg::*;
#(
  parameter int CLK_PER_US = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = clog2_min1(CLK_PER_US);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  // With CLK_PER_US=1 the counter is pinned at 0, so tick follows en.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hx8352_delay_timer.sv
// Microsecond delay timer with one-shot / auto-reload modes, abort and optional retrigger.
module hx8352_delay_timer
  import hx8352_delay_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CLK_PER_US = 1,
  parameter int RETRIGGER  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [WIDTH-1:0] delay_us,
  input  logic             periodic,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic [WIDTH-1:0] remaining,
  output logic [1:0]       state_dbg
);

  logic             step_d;
  logic             start;
  logic             load;
  logic             clr;
  logic             tick;
  logic [1:0]       state;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // step_d tracks step even in reset so a level held across reset is not an edge.
  always_ff @(posedge clk) step_d <= step;

  assign start = step & ~step_d;
  assign load  = start && ((state != ST_RUN) || (RETRIGGER != 0));
  assign clr   = abort || load;

  hx8352_us_prescaler #(.CLK_PER_US(CLK_PER_US)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
      remaining <= '0;
      reload    <= '0;
      mode      <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        remaining <= '0;
      end else if (load) begin
        if (delay_us == '0) begin
          // Zero delay completes immediately; a retrigger never pulses expired.
          state     <= ST_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          expired   <= (state != ST_RUN);
          remaining <= '0;
        end else begin
          state     <= ST_RUN;
          busy      <= 1'b1;
          done      <= 1'b0;
          remaining <= delay_us;
          reload    <= delay_us;
          mode      <= periodic;
        end
      end else if ((state == ST_RUN) && tick) begin
        if (remaining == WIDTH'(1)) begin
          expired <= 1'b1;
          if (mode) begin
            remaining <= reload;
          end else begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            remaining <= '0;
          end
        end else begin
          remaining <= remaining - WIDTH'(1);
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_hx8352_delay_timer.sv
// Bench for hx8352_delay_timer: two instances (CLK_PER_US=1/no retrigger, CLK_PER_US=5/retrigger) vs an arithmetic model.
module tb_hx8352_delay_timer;

  localparam int W = 16;
  localparam int CP [2] = '{1, 5};
  localparam int RT [2] = '{0, 1};

  logic         clk;
  logic         rst;
  logic         step;
  logic [W-1:0] delay_us;
  logic         periodic;
  logic         abort;
  logic         busy [2];
  logic         done [2];
  logic         expired [2];
  logic [W-1:0] rem [2];
  logic [1:0]   st_dbg [2];

  int n_checks;
  int n_fail;

  // Reference model: a running delay is described only by its start edge,
  // its length and its mode; everything else is derived arithmetically.
  bit     prev_step;
  longint cyc;
  bit     m_run [2];
  bit     m_done [2];
  bit     m_exp [2];
  bit     m_per [2];
  longint m_start [2];
  longint m_delay [2];

  int     exp_cnt [2];
  longint first_done [2];

  hx8352_delay_timer #(.WIDTH(W), .CLK_PER_US(1), .RETRIGGER(0)) dut0 (
    .clk(clk), .rst(rst), .step(step), .delay_us(delay_us), .periodic(periodic),
    .abort(abort), .busy(busy[0]), .done(done[0]), .expired(expired[0]),
    .remaining(rem[0]), .state_dbg(st_dbg[0])
  );

  hx8352_delay_timer #(.WIDTH(W), .CLK_PER_US(5), .RETRIGGER(1)) dut1 (
    .clk(clk), .rst(rst), .step(step), .delay_us(delay_us), .periodic(periodic),
    .abort(abort), .busy(busy[1]), .done(done[1]), .expired(expired[1]),
    .remaining(rem[1]), .state_dbg(st_dbg[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc - 1, obs, expv);
    end
  endtask

  task automatic model_step();
    bit st;
    st = step && !prev_step;
    for (int d = 0; d < 2; d++) begin
      m_exp[d] = 1'b0;
      if (rst || abort) begin
        m_run[d]  = 1'b0;
        m_done[d] = 1'b0;
      end else if (st && (!m_run[d] || RT[d] != 0)) begin
        if (delay_us == '0) begin
          m_exp[d]  = !m_run[d];
          m_run[d]  = 1'b0;
          m_done[d] = 1'b1;
        end else begin
          m_run[d]   = 1'b1;
          m_done[d]  = 1'b0;
          m_start[d] = cyc;
          m_delay[d] = longint'(delay_us);
          m_per[d]   = periodic;
        end
      end else if (m_run[d] && ((cyc - m_start[d]) % (m_delay[d] * CP[d]) == 0)) begin
        m_exp[d] = 1'b1;
        if (!m_per[d]) begin
          m_run[d]  = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
    prev_step = step;
    cyc++;
  endtask

  task automatic compare_all();
    longint k;
    longint exp_rem;
    logic [1:0] exp_st;
    for (int d = 0; d < 2; d++) begin
      k = (cyc - 1) - m_start[d];
      exp_rem = m_run[d] ? (m_delay[d] - ((k / CP[d]) % m_delay[d])) : 0;
      exp_st  = m_run[d] ? 2'd1 : (m_done[d] ? 2'd2 : 2'd0);
      check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_run[d]));
      check($sformatf("done%0d", d), 32'(done[d]), 32'(m_done[d]));
      check($sformatf("expired%0d", d), 32'(expired[d]), 32'(m_exp[d]));
      check($sformatf("remaining%0d", d), 32'(rem[d]), 32'(exp_rem));
      check($sformatf("state%0d", d), 32'(st_dbg[d]), 32'(exp_st));
      if (expired[d]) exp_cnt[d]++;
      if (done[d] && first_done[d] < 0) first_done[d] = cyc - 1;
    end
  endtask

  // Drive one cycle of inputs before the edge, then compare after the opposite edge.
  task automatic run_cycle(input bit s, input logic [W-1:0] dl, input bit p,
                           input bit ab, input bit r);
    step     = s;
    delay_us = dl;
    periodic = p;
    abort    = ab;
    rst      = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_marks();
    for (int d = 0; d < 2; d++) begin
      exp_cnt[d]    = 0;
      first_done[d] = -1;
    end
  endtask

  longint t0;
  bit     rs;
  logic [W-1:0] rd;
  bit     rp;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_step = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_done[d] = 0; m_exp[d] = 0; m_per[d] = 0;
      m_start[d] = 0; m_delay[d] = 1;
    end
    clear_marks();
    step = 0; delay_us = 0; periodic = 0; abort = 0; rst = 1;
    @(negedge clk);
    repeat (3) run_cycle(0, 0, 0, 0, 1);

    // Long one-shot with step held 30 cycles: a single expiry at +10000.
    repeat (5) run_cycle(0, 0, 0, 0, 0);
    clear_marks();
    t0 = cyc;
    repeat (30) run_cycle(1, 16'd10000, 0, 0, 0);
    repeat (10010) run_cycle(0, 16'd10000, 0, 0, 0);
    check("oneshot_latency", 32'(first_done[0] - t0), 32'd10000);
    check("oneshot_pulses", 32'(exp_cnt[0]), 32'd1);
    run_cycle(0, 0, 0, 1, 0);

    // Periodic delay of 3 us: dut1 (5 clk/us) expires every 15 cycles.
    clear_marks();
    run_cycle(1, 16'd3, 1, 0, 0);
    repeat (69) run_cycle(0, 16'd3, 1, 0, 0);
    check("periodic_pulses", 32'(exp_cnt[1]), 32'd4);
    check("periodic_done", 32'(done[1]), 32'd0);
    run_cycle(0, 16'd3, 1, 1, 0);
    clear_marks();
    repeat (40) run_cycle(0, 16'd3, 1, 0, 0);
    check("after_abort_pulses", 32'(exp_cnt[1]), 32'd0);
    check("after_abort_remaining", 32'(rem[1]), 32'd0);

    // Zero delay completes on the start edge without busy.
    clear_marks();
    run_cycle(1, 16'd0, 0, 0, 0);
    check("zero_done", 32'(done[0]), 32'd1);
    check("zero_expired", 32'(expired[0]), 32'd1);
    run_cycle(0, 16'd0, 0, 0, 0);
    check("zero_expired_width", 32'(expired[0]), 32'd0);

    // Retrigger: start 100 us, second edge 40 cycles later with 20 us.
    run_cycle(0, 0, 0, 1, 0);
    clear_marks();
    t0 = cyc;
    run_cycle(1, 16'd100, 0, 0, 0);
    repeat (39) run_cycle(0, 16'd100, 0, 0, 0);
    run_cycle(1, 16'd20, 0, 0, 0);
    repeat (200) run_cycle(0, 16'd20, 0, 0, 0);
    check("noretrig_latency", 32'(first_done[0] - t0), 32'd100);
    check("retrig_latency", 32'(first_done[1] - t0), 32'd140);
    check("retrig_pulses", 32'(exp_cnt[1]), 32'd1);

    // Abort on the cycle of the final tick.
    run_cycle(0, 0, 0, 1, 0);
    clear_marks();
    run_cycle(1, 16'd5, 0, 0, 0);
    repeat (4) run_cycle(0, 16'd5, 0, 0, 0);
    run_cycle(0, 16'd5, 0, 1, 0);
    check("abort_tick_expired", 32'(expired[0]), 32'd0);
    check("abort_tick_done", 32'(done[0]), 32'd0);
    check("abort_tick_state", 32'(st_dbg[0]), 32'd0);

    // Reset mid-count with step held; restart needs a fresh edge.
    clear_marks();
    run_cycle(1, 16'd200, 0, 0, 0);
    repeat (49) run_cycle(1, 16'd200, 0, 0, 0);
    run_cycle(1, 16'd200, 0, 0, 1);
    check("reset_busy", 32'(busy[0]), 32'd0);
    repeat (20) run_cycle(1, 16'd200, 0, 0, 0);
    check("no_restart_busy", 32'(busy[0]), 32'd0);
    run_cycle(0, 16'd200, 0, 0, 0);
    clear_marks();
    t0 = cyc;
    run_cycle(1, 16'd200, 0, 0, 0);
    repeat (210) run_cycle(0, 16'd200, 0, 0, 0);
    check("post_reset_latency", 32'(first_done[0] - t0), 32'd200);

    // Randomised traffic.
    rs = 0; rd = 16'd4; rp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rs = !rs;
        if (rs) begin
          rd = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
          rp = 1'($urandom_range(0, 1));
        end
      end
      run_cycle(rs, rd, rp, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
